// File: rtl/bbox_detect_multi.sv
// Per-channel bounding-box detector over a raster-scanned mask stream, with a
// double-buffered published result and a registered box-border overlay query.
module bbox_detect_multi #(
    parameter int H_ACT   = 1024,
    parameter int V_ACT   = 768,
    parameter int CH      = 2,
    parameter int CW      = 11,
    parameter int MIN_PIX = 64
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            frame_start,
    input  logic            pix_valid,
    input  logic [CH-1:0]   pix_mask,
    input  logic [CW-1:0]   ovl_x,
    input  logic [CW-1:0]   ovl_y,
    output logic [CH*CW-1:0] x_min,
    output logic [CH*CW-1:0] x_max,
    output logic [CH*CW-1:0] y_min,
    output logic [CH*CW-1:0] y_max,
    output logic [CH-1:0]   box_valid,
    output logic            result_stb,
    output logic [CH-1:0]   ovl_hit,
    output logic            busy
);

    localparam int CNT_W = $clog2(H_ACT * V_ACT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

    state_t state, next_state;
    logic clear_acc, accum_en, last_pix;

    logic [CW-1:0] x_cnt, y_cnt;

    logic [CW-1:0]    acc_xmin [CH];
    logic [CW-1:0]    acc_xmax [CH];
    logic [CW-1:0]    acc_ymin [CH];
    logic [CW-1:0]    acc_ymax [CH];
    logic [CNT_W-1:0] acc_cnt  [CH];

    logic [CW-1:0]    nx_xmin [CH];
    logic [CW-1:0]    nx_xmax [CH];
    logic [CW-1:0]    nx_ymin [CH];
    logic [CW-1:0]    nx_ymax [CH];
    logic [CNT_W-1:0] nx_cnt  [CH];

    logic [CH-1:0] ch_hit, hit_comb;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // A frame_start in ACCUM restarts accumulation without publishing; the
    // pixel sharing a cycle with frame_start is never accumulated.
    always_comb begin
        next_state = state;
        clear_acc  = 1'b0;
        accum_en   = 1'b0;
        last_pix   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    next_state = ACCUM;
                    clear_acc  = 1'b1;
                end
            end
            ACCUM: begin
                if (frame_start) begin
                    clear_acc = 1'b1;
                end else if (pix_valid) begin
                    accum_en = 1'b1;
                    if (x_cnt == CW'(H_ACT - 1) && y_cnt == CW'(V_ACT - 1)) begin
                        last_pix   = 1'b1;
                        next_state = PUBLISH;
                    end
                end
            end
            PUBLISH: begin
                if (frame_start) begin
                    next_state = ACCUM;
                    clear_acc  = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy       = (state == ACCUM);
    assign result_stb = (state == PUBLISH);

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            ch_hit[k]  = accum_en && pix_mask[k];
            nx_xmin[k] = (ch_hit[k] && x_cnt < acc_xmin[k]) ? x_cnt : acc_xmin[k];
            nx_xmax[k] = (ch_hit[k] && x_cnt > acc_xmax[k]) ? x_cnt : acc_xmax[k];
            nx_ymin[k] = (ch_hit[k] && y_cnt < acc_ymin[k]) ? y_cnt : acc_ymin[k];
            nx_ymax[k] = (ch_hit[k] && y_cnt > acc_ymax[k]) ? y_cnt : acc_ymax[k];
            nx_cnt[k]  = (ch_hit[k] && acc_cnt[k] != '1) ? acc_cnt[k] + CNT_W'(1) : acc_cnt[k];
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (clear_acc) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accum_en) begin
            if (x_cnt == CW'(H_ACT - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + CW'(1);
            end else begin
                x_cnt <= x_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < CH; k++) begin
                acc_xmin[k] <= '0;
                acc_xmax[k] <= '0;
                acc_ymin[k] <= '0;
                acc_ymax[k] <= '0;
                acc_cnt[k]  <= '0;
            end
        end else if (clear_acc) begin
            for (int k = 0; k < CH; k++) begin
                acc_xmin[k] <= '1;
                acc_xmax[k] <= '0;
                acc_ymin[k] <= '1;
                acc_ymax[k] <= '0;
                acc_cnt[k]  <= '0;
            end
        end else if (accum_en) begin
            for (int k = 0; k < CH; k++) begin
                acc_xmin[k] <= nx_xmin[k];
                acc_xmax[k] <= nx_xmax[k];
                acc_ymin[k] <= nx_ymin[k];
                acc_ymax[k] <= nx_ymax[k];
                acc_cnt[k]  <= nx_cnt[k];
            end
        end
    end

    // Published results load on the edge that accepts the last pixel, so they
    // are already visible during the one-cycle PUBLISH strobe.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            box_valid <= '0;
        end else if (last_pix) begin
            for (int k = 0; k < CH; k++) begin
                if (nx_cnt[k] >= CNT_W'(MIN_PIX)) begin
                    box_valid[k]       <= 1'b1;
                    x_min[k*CW +: CW]  <= nx_xmin[k];
                    x_max[k*CW +: CW]  <= nx_xmax[k];
                    y_min[k*CW +: CW]  <= nx_ymin[k];
                    y_max[k*CW +: CW]  <= nx_ymax[k];
                end else begin
                    box_valid[k]       <= 1'b0;
                    x_min[k*CW +: CW]  <= '0;
                    x_max[k*CW +: CW]  <= '0;
                    y_min[k*CW +: CW]  <= '0;
                    y_max[k*CW +: CW]  <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            hit_comb[k] = box_valid[k] && (
                ((ovl_x == x_min[k*CW +: CW] || ovl_x == x_max[k*CW +: CW]) &&
                 ovl_y >= y_min[k*CW +: CW] && ovl_y <= y_max[k*CW +: CW]) ||
                ((ovl_y == y_min[k*CW +: CW] || ovl_y == y_max[k*CW +: CW]) &&
                 ovl_x >= x_min[k*CW +: CW] && ovl_x <= x_max[k*CW +: CW]));
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) ovl_hit <= '0;
        else       ovl_hit <= hit_comb;
    end

endmodule

// File: tb/tb_bbox_detect_multi.sv
// Randomized scoreboard bench for bbox_detect_multi: frames are modelled as
// lists of hit pixels, expected publishes are queued and checked by a monitor.
module tb_bbox_detect_multi;

    localparam int H_ACT   = 8;
    localparam int V_ACT   = 4;
    localparam int CH      = 2;
    localparam int CW      = 4;
    localparam int MIN_PIX = 2;
    localparam int NPIX    = H_ACT * V_ACT;

    typedef struct packed {
        logic [CH-1:0]    bv;
        logic [CH*CW-1:0] xmn;
        logic [CH*CW-1:0] xmx;
        logic [CH*CW-1:0] ymn;
        logic [CH*CW-1:0] ymx;
        int               cyc;
    } exp_t;

    logic clk, rst;
    logic frame_start, pix_valid;
    logic [CH-1:0] pix_mask;
    logic [CW-1:0] ovl_x, ovl_y;
    logic [CH*CW-1:0] x_min, x_max, y_min, y_max;
    logic [CH-1:0] box_valid, ovl_hit;
    logic result_stb, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [CH-1:0] pat [NPIX];
    exp_t exp_q [$];
    logic [2*CW-1:0] ovl_q [$];
    exp_t pub;
    logic [CH-1:0] exp_ovl;

    bbox_detect_multi #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .CH(CH), .CW(CW), .MIN_PIX(MIN_PIX)
    ) dut (
        .clk(clk), .Reset(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_mask(pix_mask), .ovl_x(ovl_x), .ovl_y(ovl_y),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .box_valid(box_valid), .result_stb(result_stb), .ovl_hit(ovl_hit), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: box is min/max over the hit pixels, pixel i sits at (i%H, i/H).
    function automatic exp_t model_frame(input int stb_cyc);
        exp_t e;
        e = '0;
        e.cyc = stb_cyc;
        for (int k = 0; k < CH; k++) begin
            int cnt = 0, mnx = 1000, mxx = -1, mny = 1000, mxy = -1;
            for (int i = 0; i < NPIX; i++) begin
                if (pat[i][k]) begin
                    cnt++;
                    if (i % H_ACT < mnx) mnx = i % H_ACT;
                    if (i % H_ACT > mxx) mxx = i % H_ACT;
                    if (i / H_ACT < mny) mny = i / H_ACT;
                    if (i / H_ACT > mxy) mxy = i / H_ACT;
                end
            end
            if (cnt >= MIN_PIX) begin
                e.bv[k] = 1'b1;
                e.xmn[k*CW +: CW] = CW'(mnx);
                e.xmx[k*CW +: CW] = CW'(mxx);
                e.ymn[k*CW +: CW] = CW'(mny);
                e.ymx[k*CW +: CW] = CW'(mxy);
            end
        end
        return e;
    endfunction

    function automatic logic [CH-1:0] ovl_model(input exp_t p, input int qx, input int qy);
        logic [CH-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            int a = p.xmn[k*CW +: CW], b = p.xmx[k*CW +: CW];
            int c = p.ymn[k*CW +: CW], d = p.ymx[k*CW +: CW];
            if (p.bv[k] && (((qx == a || qx == b) && qy >= c && qy <= d) ||
                            ((qy == c || qy == d) && qx >= a && qx <= b)))
                r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic applyStimulus(input bit fs, input bit pv, input logic [CH-1:0] m);
        @(negedge clk);
        frame_start = fs;
        pix_valid   = pv;
        pix_mask    = m;
    endtask

    // abort_at < 0 runs a complete frame; gaps: 0 none, 1 every other cycle, 2 random
    task automatic run_frame(input int gaps, input int abort_at);
        applyStimulus(1'b1, 1'b1, '1);
        for (int i = 0; i < NPIX; i++) begin
            if (i == abort_at) return;
            if (gaps == 1) applyStimulus(1'b0, 1'b0, CH'($urandom_range(0, 3)));
            else if (gaps == 2) repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, CH'($urandom_range(0, 3)));
            applyStimulus(1'b0, 1'b1, pat[i]);
            if (i == NPIX - 1) exp_q.push_back(model_frame(cyc + 1));
        end
    endtask

    task automatic idle_junk(input int n);
        repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), CH'($urandom_range(0, 3)));
    endtask

    task automatic set_pat_random(input int d0, input int d1);
        for (int i = 0; i < NPIX; i++) begin
            pat[i][0] = ($urandom_range(0, 99) < d0);
            pat[i][1] = ($urandom_range(0, 99) < d1);
        end
    endtask

    task automatic set_pat_req38();
        for (int i = 0; i < NPIX; i++) pat[i] = '0;
        pat[1*H_ACT + 2][0] = 1'b1;
        pat[1*H_ACT + 5][0] = 1'b1;
        pat[3*H_ACT + 3][0] = 1'b1;
    endtask

    // Monitor: checks reset values, overlay response and every publish.
    initial begin
        exp_ovl = '0;
        pub = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                checkOutput("reset_outputs",
                    64'({x_min, x_max, y_min, y_max, box_valid, result_stb, ovl_hit, busy}), 64'd0);
                pub = '0;
            end else begin
                checkOutput("ovl_hit", 64'(ovl_hit), 64'(exp_ovl));
                if (result_stb) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_result_stb", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("stb_cycle", 64'(cyc), 64'(e.cyc));
                        checkOutput("box_valid", 64'(box_valid), 64'(e.bv));
                        checkOutput("x_min", 64'(x_min), 64'(e.xmn));
                        checkOutput("x_max", 64'(x_max), 64'(e.xmx));
                        checkOutput("y_min", 64'(y_min), 64'(e.ymn));
                        checkOutput("y_max", 64'(y_max), 64'(e.ymx));
                        pub = e;
                    end
                end
            end
            if (ovl_q.size() != 0) begin
                {ovl_x, ovl_y} = ovl_q.pop_front();
            end else if ($urandom_range(0, 1) == 1) begin
                int k = $urandom_range(0, CH - 1);
                int a = pub.xmn[k*CW +: CW], b = pub.xmx[k*CW +: CW];
                int c = pub.ymn[k*CW +: CW], d = pub.ymx[k*CW +: CW];
                if ($urandom_range(0, 1) == 1) begin
                    ovl_x = CW'(($urandom_range(0, 1) == 1) ? a : b);
                    ovl_y = CW'($urandom_range(0, 15));
                end else begin
                    ovl_x = CW'($urandom_range(0, 15));
                    ovl_y = CW'(($urandom_range(0, 1) == 1) ? c : d);
                end
            end else begin
                ovl_x = CW'($urandom_range(0, 15));
                ovl_y = CW'($urandom_range(0, 15));
            end
            exp_ovl = rst ? '0 : ovl_model(pub, int'(ovl_x), int'(ovl_y));
        end
    end

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_mask = '0;
        ovl_x = '0;
        ovl_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_junk(4);

        $display("[TB] directed full frame");
        set_pat_req38();
        run_frame(0, -1);
        idle_junk(3);
        ovl_q.push_back({4'd2, 4'd2});
        ovl_q.push_back({4'd3, 4'd2});
        ovl_q.push_back({4'd5, 4'd4});
        idle_junk(6);

        $display("[TB] single hit below threshold");
        for (int i = 0; i < NPIX; i++) pat[i] = '0;
        pat[NPIX - 1][1] = 1'b1;
        run_frame(0, -1);
        idle_junk(3);

        $display("[TB] abort after 20 pixels");
        set_pat_random(30, 30);
        run_frame(0, 20);
        set_pat_random(10, 40);
        run_frame(0, -1);
        idle_junk(3);

        $display("[TB] gapped pixel stream");
        set_pat_req38();
        run_frame(1, -1);
        idle_junk(4);

        $display("[TB] reset mid-frame");
        set_pat_random(40, 40);
        run_frame(2, 12);
        @(negedge clk);
        rst = 1'b1;
        idle_junk(3);
        @(negedge clk);
        rst = 1'b0;
        idle_junk(2);
        set_pat_random(15, 15);
        run_frame(0, -1);
        idle_junk(3);

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            set_pat_random($urandom_range(0, 3) * 8, $urandom_range(0, 3) * 8);
            if ($urandom_range(0, 4) == 0) run_frame($urandom_range(0, 2), $urandom_range(1, NPIX - 1));
            else run_frame($urandom_range(0, 2), -1);
            if ($urandom_range(0, 1) == 1) idle_junk($urandom_range(1, 4));
        end
        idle_junk(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("pending_results", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
